unidade_controle_jogo: RTL and testbench
========================================

Name: unidade_controle_jogo

Overview:
- Moore control unit that sequences the memory-game datapath: address counter E, round counter L, button register R, comparator and end-of-count flags.
- Runs the round/play loop, detects button presses by edge, and times player inactivity with an internal counter.
- Drives all datapath zero/count/register strobes, the ganhou/perdeu/pronto status outputs and the db_estado debug code.
- Sits inside circuito_jogo_base between the external jogar/botoes inputs and the datapath.

Parameters:
- TIMEOUT_CYCLES, 3000, clock cycles of inactivity in espera_jogada before timeout (>=2).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; forces state inicial.
- jogar  in  1  start/restart request, level-sampled.
- tem_jogada  in  1  OR of botoes from datapath; level.
- igual  in  1  comparator: R equals memory at address E.
- fimE  in  1  address counter E equals current round limit L.
- fimL  in  1  round counter L at last round.
- zeraE  out  1  clear address counter.
- contaE  out  1  increment address counter.
- zeraL  out  1  clear round counter.
- contaL  out  1  increment round counter.
- zeraR  out  1  clear button register.
- registraR  out  1  load button register.
- ganhou  out  1  win status.
- perdeu  out  1  loss status (wrong play or timeout).
- pronto  out  1  game finished.
- db_timeout  out  1  loss was by timeout.
- db_jogada  out  1  one-cycle rising edge of tem_jogada.
- db_estado  out  4  current state code.

Behaviour:
- Reset: state inicial, timer=0, edge register=0. All outputs 0 while in inicial; db_estado=0.
- Edge detect: prev <= tem_jogada every cycle; db_jogada = tem_jogada & ~prev (combinational). Only db_jogada advances play. A held button counts once.
- States (code):
  - inicial (0): jogar -> preparacao.
  - preparacao (1): zeraE, zeraL, zeraR -> inicio_rodada.
  - inicio_rodada (2): zeraE -> espera_jogada.
  - espera_jogada (3): timer increments. If db_jogada -> registra. Else if timer==TIMEOUT_CYCLES-1 -> fim_timeout. db_jogada wins when both occur in the same cycle.
  - registra (4): registraR -> comparacao.
  - comparacao (5): !igual -> fim_perdeu; igual&fimE&fimL -> fim_ganhou; igual&fimE&!fimL -> proxima_rodada; igual&!fimE -> proxima_jogada.
  - proxima_jogada (7): contaE -> espera_jogada.
  - proxima_rodada (6): contaL -> inicio_rodada.
  - fim_ganhou (A): pronto=1, ganhou=1.
  - fim_perdeu (E): pronto=1, perdeu=1.
  - fim_timeout (D): pronto=1, perdeu=1, db_timeout=1.
  - In A/E/D: jogar -> preparacao, else hold.
- Unused codes 8, 9, B, C, F -> inicial on next clock.
- Outputs are pure decode of state (Moore); each strobe is high exactly one cycle per state visit.
- Latency: edge seen at cycle n in espera_jogada -> registraR at n+1 -> decision at n+2 -> contaE/contaL/terminal state at n+3.
- Timer: width clog2(TIMEOUT_CYCLES). Counts only in espera_jogada; held at 0 in every other state, so each play gets a full window. It never wraps because it exits at TIMEOUT_CYCLES-1.
- jogar is ignored outside inicial and the terminal states.
- tem_jogada is ignored outside espera_jogada, but prev still tracks it: a button held across registra/proxima_jogada does not retrigger.
- Reset mid-game: immediate return to inicial, timer and prev cleared, outputs 0.

Test Plan:
- Reset pulse, then jogar=1 for 10 cycles -> db_estado 0->1->2->3; zeraE/zeraL/zeraR pulse once in state 1; perdeu=ganhou=pronto=0.
- Round 0, igual=1, fimE=1, fimL=0, press held 10 cycles -> exactly one registraR, then contaL one cycle (state 6), back to state 3 via 2.
- Round 1, two presses with igual=1, fimE=0 then 1 -> contaE once (state 7) between plays, then contaL; no extra strobes while button held.
- No press in espera_jogada with TIMEOUT_CYCLES=3000 -> state D exactly 3000 cycles after entry; pronto=perdeu=db_timeout=1, ganhou=0. Then jogar -> state 1.
- Press with igual=0 -> state E, perdeu=1, db_timeout=0. Press with igual=fimE=fimL=1 -> state A, ganhou=1, pronto=1.
- db_jogada and timer terminal in the same cycle -> registra (4), not D. Async reset asserted in state 5 -> state 0 and all outputs 0 before the next clock edge.

Source files
------------

// File: rtl/unidade_controle_jogo.sv
// Moore control unit for the memory game datapath.
// Sequences rounds and plays, detects button presses by rising edge and
// times player inactivity while waiting for a play.
//
// Ports:
//   clock       system clock, rising edge
//   reset       asynchronous, active-high; returns to inicial
//   jogar       start/restart request (level)
//   tem_jogada  OR of the buttons (level)
//   igual       button register matches memory at address E
//   fimE        address counter E reached the current round limit
//   fimL        round counter L at last round
//   zeraE/contaE, zeraL/contaL, zeraR/registraR  datapath strobes
//   ganhou/perdeu/pronto  game status
//   db_timeout  loss was caused by inactivity
//   db_jogada   one-cycle pulse on rising edge of tem_jogada
//   db_estado   current state code
module unidade_controle_jogo #(
  parameter int unsigned TIMEOUT_CYCLES = 3000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       jogar,
  input  logic       tem_jogada,
  input  logic       igual,
  input  logic       fimE,
  input  logic       fimL,
  output logic       zeraE,
  output logic       contaE,
  output logic       zeraL,
  output logic       contaL,
  output logic       zeraR,
  output logic       registraR,
  output logic       ganhou,
  output logic       perdeu,
  output logic       pronto,
  output logic       db_timeout,
  output logic       db_jogada,
  output logic [3:0] db_estado
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TIMER_FIM = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [3:0] {
    INICIAL        = 4'h0,
    PREPARACAO     = 4'h1,
    INICIO_RODADA  = 4'h2,
    ESPERA_JOGADA  = 4'h3,
    REGISTRA       = 4'h4,
    COMPARACAO     = 4'h5,
    PROXIMA_RODADA = 4'h6,
    PROXIMA_JOGADA = 4'h7,
    FIM_GANHOU     = 4'hA,
    FIM_TIMEOUT    = 4'hD,
    FIM_PERDEU     = 4'hE
  } t_estado;

  t_estado       r_estado;
  t_estado       w_proximo;
  logic [TW-1:0] r_timer;
  logic          r_prev;
  logic          w_jogada;

  logic r_zeraE, r_contaE, r_zeraL, r_contaL, r_zeraR, r_registraR;
  logic r_ganhou, r_perdeu, r_pronto, r_timeout;

  assign w_jogada = tem_jogada & ~r_prev;

  always_comb begin
    w_proximo = r_estado;
    unique case (r_estado)
      INICIAL:        if (jogar) w_proximo = PREPARACAO;
      PREPARACAO:     w_proximo = INICIO_RODADA;
      INICIO_RODADA:  w_proximo = ESPERA_JOGADA;
      ESPERA_JOGADA: begin
        // A press in the final timer cycle still counts as a play.
        if (w_jogada)                w_proximo = REGISTRA;
        else if (r_timer == TIMER_FIM) w_proximo = FIM_TIMEOUT;
      end
      REGISTRA:       w_proximo = COMPARACAO;
      COMPARACAO: begin
        if (!igual)           w_proximo = FIM_PERDEU;
        else if (fimE && fimL) w_proximo = FIM_GANHOU;
        else if (fimE)        w_proximo = PROXIMA_RODADA;
        else                  w_proximo = PROXIMA_JOGADA;
      end
      PROXIMA_JOGADA: w_proximo = ESPERA_JOGADA;
      PROXIMA_RODADA: w_proximo = INICIO_RODADA;
      FIM_GANHOU, FIM_PERDEU, FIM_TIMEOUT:
        if (jogar) w_proximo = PREPARACAO;
      default:        w_proximo = INICIAL;
    endcase
  end

  // Outputs are registered from the next state so they equal a decode of
  // the state register while still clearing immediately on reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_estado    <= INICIAL;
      r_timer     <= '0;
      r_prev      <= 1'b0;
      r_zeraE     <= 1'b0;
      r_contaE    <= 1'b0;
      r_zeraL     <= 1'b0;
      r_contaL    <= 1'b0;
      r_zeraR     <= 1'b0;
      r_registraR <= 1'b0;
      r_ganhou    <= 1'b0;
      r_perdeu    <= 1'b0;
      r_pronto    <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_estado <= w_proximo;
      r_prev   <= tem_jogada;
      if (r_estado == ESPERA_JOGADA && w_proximo == ESPERA_JOGADA)
        r_timer <= r_timer + TW'(1);
      else
        r_timer <= '0;
      r_zeraE     <= (w_proximo == PREPARACAO) || (w_proximo == INICIO_RODADA);
      r_contaE    <= (w_proximo == PROXIMA_JOGADA);
      r_zeraL     <= (w_proximo == PREPARACAO);
      r_contaL    <= (w_proximo == PROXIMA_RODADA);
      r_zeraR     <= (w_proximo == PREPARACAO);
      r_registraR <= (w_proximo == REGISTRA);
      r_ganhou    <= (w_proximo == FIM_GANHOU);
      r_perdeu    <= (w_proximo == FIM_PERDEU) || (w_proximo == FIM_TIMEOUT);
      r_pronto    <= (w_proximo == FIM_GANHOU) || (w_proximo == FIM_PERDEU) ||
                     (w_proximo == FIM_TIMEOUT);
      r_timeout   <= (w_proximo == FIM_TIMEOUT);
    end
  end

  assign zeraE      = r_zeraE;
  assign contaE     = r_contaE;
  assign zeraL      = r_zeraL;
  assign contaL     = r_contaL;
  assign zeraR      = r_zeraR;
  assign registraR  = r_registraR;
  assign ganhou     = r_ganhou;
  assign perdeu     = r_perdeu;
  assign pronto     = r_pronto;
  assign db_timeout = r_timeout;
  assign db_jogada  = w_jogada;
  assign db_estado  = r_estado;

endmodule

// File: tb/tb_unidade_controle_jogo.sv
// Self-checking bench for unidade_controle_jogo: directed game scenarios
// followed by randomized play, checked against a transaction-level model.
module tb_unidade_controle_jogo;

  localparam int T = 3000;

  logic clock = 1'b0;
  logic reset, jogar, tem_jogada, igual, fimE, fimL;
  logic zeraE, contaE, zeraL, contaL, zeraR, registraR;
  logic ganhou, perdeu, pronto, db_timeout, db_jogada;
  logic [3:0] db_estado;

  int total = 0;
  int bad = 0;

  // Model: current code, queue of forced upcoming codes, cycles spent waiting.
  int m_code;
  int m_q[$];
  int m_wait;
  bit m_prev;

  unidade_controle_jogo #(.TIMEOUT_CYCLES(T)) dut (
    .clock(clock), .reset(reset), .jogar(jogar), .tem_jogada(tem_jogada),
    .igual(igual), .fimE(fimE), .fimL(fimL),
    .zeraE(zeraE), .contaE(contaE), .zeraL(zeraL), .contaL(contaL),
    .zeraR(zeraR), .registraR(registraR), .ganhou(ganhou), .perdeu(perdeu),
    .pronto(pronto), .db_timeout(db_timeout), .db_jogada(db_jogada),
    .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] dut_outs();
    return {zeraE, contaE, zeraL, contaL, zeraR, registraR,
            ganhou, perdeu, pronto, db_timeout};
  endfunction

  // Expected strobes/status for a state code, from the per-state rules.
  function automatic logic [9:0] exp_outs(input int c);
    logic [9:0] v;
    v = '0;
    v[9] = (c == 1) || (c == 2);
    v[8] = (c == 7);
    v[7] = (c == 1);
    v[6] = (c == 6);
    v[5] = (c == 1);
    v[4] = (c == 4);
    v[3] = (c == 10);
    v[2] = (c == 13) || (c == 14);
    v[1] = (c == 10) || (c == 13) || (c == 14);
    v[0] = (c == 13);
    return v;
  endfunction

  task automatic model_reset();
    m_code = 0;
    m_q.delete();
    m_wait = 0;
    m_prev = 0;
  endtask

  // Advance the model by one clock using the inputs present before the edge.
  task automatic model_advance();
    bit edge_seen;
    edge_seen = tem_jogada && !m_prev;
    if (reset) begin
      model_reset();
    end else if (m_q.size() > 0) begin
      m_code = m_q.pop_front();
      if (m_code == 3) m_wait = 0;
    end else begin
      case (m_code)
        0, 10, 13, 14: if (jogar) begin m_code = 1; m_q = '{2, 3}; end
        3: begin
          if (edge_seen) begin m_code = 4; m_q = '{5}; end
          else if (m_wait == T - 1) m_code = 13;
          else m_wait++;
        end
        5: begin
          if (!igual) m_code = 14;
          else if (fimE && fimL) m_code = 10;
          else if (fimE) begin m_code = 6; m_q = '{2, 3}; end
          else begin m_code = 7; m_q = '{3}; end
        end
        default: m_code = 0;
      endcase
    end
  endtask

  task automatic step();
    #1;
    chk("db_jogada", 16'(db_jogada), 16'(tem_jogada && !m_prev));
    model_advance();
    @(posedge clock);
    m_prev = reset ? 1'b0 : tem_jogada;
    #1;
    chk("db_estado", 16'(db_estado), 16'(m_code));
    chk("outputs", 16'(dut_outs()), 16'(exp_outs(m_code)));
  endtask

  initial begin
    int cnt;
    int n_reg;
    reset = 1'b1; jogar = 0; tem_jogada = 0; igual = 0; fimE = 0; fimL = 0;
    model_reset();
    #3;
    chk("reset_estado", 16'(db_estado), 16'd0);
    chk("reset_outs", 16'(dut_outs()), 16'd0);
    @(posedge clock); #1;
    reset = 1'b0;

    // Start: 0 -> 1 -> 2 -> 3, jogar held and then ignored.
    jogar = 1;
    repeat (10) step();
    jogar = 0;
    chk("start_in_espera", 16'(db_estado), 16'd3);

    // Round 0: held press counts once, then next round.
    igual = 1; fimE = 1; fimL = 0; tem_jogada = 1;
    n_reg = 0;
    repeat (10) begin step(); if (registraR) n_reg++; end
    chk("single_registraR", 16'(n_reg), 16'd1);
    tem_jogada = 0;
    step();

    // Round 1: first play continues the round, second ends it.
    fimE = 0; tem_jogada = 1;
    repeat (6) step();
    tem_jogada = 0;
    repeat (2) step();
    fimE = 1; tem_jogada = 1;
    repeat (4) step();
    tem_jogada = 0;

    // Inactivity: count cycles spent in espera_jogada before timeout.
    cnt = 0;
    for (int i = 0; i < T + 20; i++) begin
      step();
      if (db_estado == 4'd3) cnt++;
      else if (cnt > 0) break;
    end
    chk("timeout_cycles", 16'(cnt), 16'(T));
    chk("timeout_estado", 16'(db_estado), 16'hD);
    jogar = 1; step(); jogar = 0;
    chk("restart_after_timeout", 16'(db_estado), 16'd1);
    repeat (2) step();

    // Wrong play -> loss.
    igual = 0; tem_jogada = 1;
    repeat (3) step();
    chk("perdeu_estado", 16'(db_estado), 16'hE);
    tem_jogada = 0; jogar = 1; step(); jogar = 0;
    repeat (2) step();

    // Correct play on the last position of the last round -> win.
    igual = 1; fimE = 1; fimL = 1; tem_jogada = 1;
    repeat (3) step();
    chk("ganhou_estado", 16'(db_estado), 16'hA);
    tem_jogada = 0; jogar = 1; step(); jogar = 0;
    repeat (2) step();

    // Press arriving in the timer's final cycle wins over timeout.
    fimL = 0;
    for (int i = 0; i < T + 20 && !(m_code == 3 && m_wait == T - 1); i++) step();
    chk("tie_reached", 16'(m_wait), 16'(T - 1));
    tem_jogada = 1;
    step();
    chk("tie_registra", 16'(db_estado), 16'd4);
    step();
    chk("in_comparacao", 16'(db_estado), 16'd5);

    // Asynchronous reset mid-cycle in comparacao.
    #1 reset = 1'b1;
    #1;
    chk("async_reset_estado", 16'(db_estado), 16'd0);
    chk("async_reset_outs", 16'(dut_outs()), 16'd0);
    model_reset();
    step();
    reset = 1'b0;
    tem_jogada = 0;

    // Randomized play.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(3) == 0) tem_jogada = ~tem_jogada;
      jogar = ($urandom_range(15) == 0);
      igual = ($urandom_range(7) != 0);
      fimE  = $urandom_range(1);
      fimL  = ($urandom_range(3) == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
